drm_activator_multi_bfm: RTL

Parametrised successor to the single-activator simulation settings. A synthesizable controller BFM that unlocks NUM_CH DRM activator channels over one shared key-load stream. Each channel is served round-robin: the BFM sends the key, waits for an acknowledge with a timeout, and retries a bounded number of times. It keeps per-channel metering counters. It sits in the simulation top in place of the real DRM controller. For synthesis, USE_BFM=0 and the block is not instantiated.

---
 rtl/drm_activator_multi_bfm_pkg.sv | 20 ++
 rtl/drm_bfm_rr_arbiter.sv | 29 ++
 rtl/drm_activator_multi_bfm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/drm_activator_multi_bfm_pkg.sv
// Shared state type, channel-width helper and defaults for the multi-channel DRM activator BFM.
package drm_activator_multi_bfm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARB      = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } fsm_state_e;

    localparam logic [127:0] DEFAULT_LICENSE_KEY = 128'h0;

    // Simulation tops instantiate the BFM only when set; synthesis builds leave the block out.
    localparam bit USE_BFM = 1'b1;

    function automatic int CH_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drm_bfm_rr_arbiter.sv
// Combinational round-robin pick: lowest pending channel at or above rr_ptr, wrapping.
module drm_bfm_rr_arbiter
    import drm_activator_multi_bfm_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CHW   = CH_W(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CHW-1:0]    rr_ptr,
    output logic [CHW-1:0]    grant,
    output logic              grant_vld
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (!grant_vld && pending[idx]) begin
                grant     = CHW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drm_activator_multi_bfm.sv
// Controller BFM unlocking NUM_CH DRM activators over one shared key stream, with retries and metering.
// Optional DRM_BFM_MESSAGE_EN compiles in $display trace messages; behaviour is identical without it.
module drm_activator_multi_bfm
    import drm_activator_multi_bfm_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 32,
    parameter int KEY_WORDS   = 4,
    parameter logic [KEY_WORDS*DATA_W-1:0] LICENSE_KEY = DEFAULT_LICENSE_KEY,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 32,
    localparam int CHW        = CH_W(NUM_CH)
) (
    input  logic                    drm_aclk,
    input  logic                    drm_arst,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic                    key_valid,
    input  logic                    key_ready,
    output logic [DATA_W-1:0]       key_data,
    output logic [CHW-1:0]          key_ch,
    output logic                    key_last,
    input  logic                    ack_valid,
    input  logic [CHW-1:0]          ack_ch,
    input  logic                    ack_ok,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ch_error,
    input  logic [NUM_CH-1:0]       meter_tick,
    output logic [NUM_CH*CNT_W-1:0] meter_cnt,
    output logic                    busy
);

    localparam int WW = CH_W(KEY_WORDS);
    localparam int RW = CH_W(MAX_RETRY + 1);
    localparam int TW = CH_W(TIMEOUT_CYC);

    fsm_state_e        state_q, state_d;
    logic [CHW-1:0]    ch_q, rr_q, grant;
    logic              grant_vld;
    logic [WW-1:0]     word_q;
    logic [RW-1:0]     retry_q;
    logic [TW-1:0]     tmr_q;
    logic [NUM_CH-1:0] pending_q, active_q, error_q;
    logic [CNT_W-1:0]  meter_q [NUM_CH];

    logic word_end, tmr_end, ack_match, nack_evt, tmo_evt;
    logic do_load, do_grant, do_word, do_ok, do_retry, do_fail;

    drm_bfm_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending   (pending_q),
        .rr_ptr    (rr_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign word_end  = (int'(word_q) == KEY_WORDS - 1);
    assign tmr_end   = (int'(tmr_q) == TIMEOUT_CYC - 1);
    assign ack_match = ack_valid && (ack_ch == ch_q);
    // A matching ack in the timeout cycle takes precedence over the timeout.
    assign nack_evt  = (state_q == WAIT_ACK) && ack_match && !ack_ok;
    assign tmo_evt   = (state_q == WAIT_ACK) && !ack_match && tmr_end;

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        key_valid = 1'b0;
        do_load   = 1'b0;
        do_grant  = 1'b0;
        do_word   = 1'b0;
        do_ok     = 1'b0;
        do_retry  = 1'b0;
        do_fail   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                do_load = 1'b1;
                state_d = ARB;
            end
            ARB: if (grant_vld) begin
                do_grant = 1'b1;
                state_d  = SEND;
            end else begin
                state_d  = IDLE;
            end
            SEND: begin
                key_valid = 1'b1;
                if (key_ready) begin
                    do_word = 1'b1;
                    if (word_end) state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: if (ack_match && ack_ok) begin
                do_ok   = 1'b1;
                state_d = ARB;
            end else if (nack_evt || tmo_evt) begin
                if (int'(retry_q) < MAX_RETRY) begin
                    do_retry = 1'b1;
                    state_d  = SEND;
                end else begin
                    do_fail  = 1'b1;
                    state_d  = ARB;
                end
            end
            default: state_d = IDLE;
        endcase
        key_data = key_valid ? LICENSE_KEY[int'(word_q)*DATA_W +: DATA_W] : '0;
        key_ch   = key_valid ? ch_q : '0;
        key_last = key_valid && word_end;
    end

    always_ff @(posedge drm_aclk) begin
        if (drm_arst) begin
            ch_q      <= '0;
            rr_q      <= '0;
            word_q    <= '0;
            retry_q   <= '0;
            tmr_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            error_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) meter_q[i] <= '0;
        end else begin
            // Errored channels are excluded too, so no channel can end up both active and errored.
            if (do_load) pending_q <= ch_en & ~(active_q | error_q);
            if (do_grant) begin
                ch_q    <= grant;
                word_q  <= '0;
                retry_q <= '0;
            end
            if (do_word) word_q <= word_end ? '0 : word_q + 1'b1;
            tmr_q <= (state_q == WAIT_ACK) ? tmr_q + 1'b1 : '0;
            if (do_ok) begin
                active_q[ch_q]  <= 1'b1;
                pending_q[ch_q] <= 1'b0;
                rr_q            <= (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
            end
            if (do_retry) retry_q <= retry_q + 1'b1;
            if (do_fail) begin
                error_q[ch_q]   <= 1'b1;
                pending_q[ch_q] <= 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (meter_tick[i] && active_q[i] && meter_q[i] != '1)
                    meter_q[i] <= meter_q[i] + 1'b1;
            end
        end
    end

    assign ch_active = active_q;
    assign ch_error  = error_q;

    always_comb begin
        meter_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) meter_cnt[i*CNT_W +: CNT_W] = meter_q[i];
    end

`ifdef DRM_BFM_MESSAGE_EN
    always @(posedge drm_aclk) begin
        if (!drm_arst) begin
            if (do_ok)    $display("%0t drm_bfm: ch %0d activated, retries %0d", $time, ch_q, retry_q);
            if (nack_evt) $display("%0t drm_bfm: ch %0d NACK, retries %0d", $time, ch_q, retry_q);
            if (tmo_evt)  $display("%0t drm_bfm: ch %0d ack timeout, retries %0d", $time, ch_q, retry_q);
            if (do_fail)  $display("%0t drm_bfm: ch %0d error, retries %0d", $time, ch_q, retry_q);
        end
    end
`else
    // Silent build: no system tasks, fully synthesizable.
`endif

endmodule
